split_sched: RTL

SPLIT_SCHED -- requirements
Module: split_sched

---
 rtl/split_sched_pkg.sv | 35 +++
 rtl/split_sched_if.sv | 43 ++++
 rtl/split_sched_credit.sv | 51 +++++
 rtl/split_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/split_sched_pkg.sv
// ---------------------------------------------------------------------------
// split_sched_pkg
// Shared definitions for the split scheduler:
//   - flit type encodings carried in the top two bits of every flit
//   - FSM state enumeration used by split_sched
//   - default flit width and downstream credit depth
//   - credit counter width (fixed at 4 bits, so CREDITS is limited to 1..15)
// ---------------------------------------------------------------------------
package split_sched_pkg;

  localparam int DEF_WIDTH   = 11;
  localparam int DEF_CREDITS = 4;
  localparam int CRED_W      = 4;

  // Flit type field: [WIDTH-1:WIDTH-2]
  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_TAIL = 2'b01,
    FT_HEAD = 2'b10,
    FT_HT   = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_e;

  // Head and head+tail both carry a route bit and both open arbitration;
  // they share the upper type bit.
  function automatic logic is_head(input logic [1:0] ftype);
    return ftype[1];
  endfunction

endpackage

// File: rtl/split_sched_if.sv
// ---------------------------------------------------------------------------
// split_sched_if
// Bundles the two requester inputs, the shared output handshake, the
// per-output credit returns and the grant/err status of the split scheduler.
//   in0_*/in1_*  : requester flit, valid, ready
//   out_*        : flit, split control token, valid/ready to the split path
//   cred_ret     : one-cycle credit return pulse per split output
//   grant, err   : current path owner (one-hot) and orphan flit pulse
// Modports:
//   master : requester/downstream side (drives flits, out_ready, cred_ret)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface split_sched_if
  import split_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] in0_data;
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       cred_ret;
  logic [1:0]       grant;
  logic             err;

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready, cred_ret,
    input  in0_ready, in1_ready, out_data, out_ctrl, out_valid, grant, err
  );

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready, cred_ret,
    output in0_ready, in1_ready, out_data, out_ctrl, out_valid, grant, err
  );

endinterface

// File: rtl/split_sched_credit.sv
// ---------------------------------------------------------------------------
// split_credit
// Credit counter for one split output. Starts full (CREDITS), counts down
// on every flit sent to that output and up on each credit return pulse.
// A send and a return in the same cycle cancel; returns beyond CREDITS are
// dropped so a spurious pulse cannot inflate the window.
// Ports:
//   clk     : clock
//   _reset  : synchronous active-low reset
//   dec     : a flit for this output is accepted this cycle
//   inc     : credit return pulse from the downstream buffer
//   avail   : at least one credit is available
// ---------------------------------------------------------------------------
module split_credit
  import split_sched_pkg::*;
#(
  parameter int CREDITS = DEF_CREDITS
) (
  input  logic clk,
  input  logic _reset,
  input  logic dec,
  input  logic inc,
  output logic avail
);

  localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0] ONE      = CRED_W'(1);

  logic [CRED_W-1:0] count_reg;
  logic [CRED_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (dec && !inc) begin
      count_next = count_reg - ONE;
    end else if (inc && !dec && (count_reg != MAX_CRED)) begin
      count_next = count_reg + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      count_reg <= MAX_CRED;
    end else begin
      count_reg <= count_next;
    end
  end

  assign avail = (count_reg != '0);

endmodule

// File: rtl/split_sched.sv
// ---------------------------------------------------------------------------
// split_sched
// Packet scheduler in front of a shared split datapath. Two requesters
// compete for the path with round-robin arbitration on head flits; the
// winner of a multi-flit packet locks the path until its tail is accepted.
// The route bit of the head selects the split output (out_ctrl) for every
// flit of the packet, and a per-output credit counter throttles sending.
// Accepted flits are registered: latency 1, one flit per cycle.
// Ports:
//   clk     : clock
//   _reset  : synchronous active-low reset
//   bus     : split_sched_if slave modport (inputs, output, credits, status)
// ---------------------------------------------------------------------------
module split_sched
  import split_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CREDITS = DEF_CREDITS
) (
  input  logic          clk,
  input  logic          _reset,
  split_sched_if.slave  bus
);

  localparam int TYPE_MSB  = WIDTH - 1;
  localparam int ROUTE_BIT = WIDTH - 3;

  // FSM and packet context
  state_e state_reg, state_next;
  logic   route_reg, route_next;
  logic   last_reg,  last_next;   // input granted most recently (1 = in1)

  // Output register
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_ctrl_reg;

  // Input decode
  logic [WIDTH-1:0] in_data [2];
  logic [1:0]       in_type [2];
  logic [1:0]       in_valid;
  logic [1:0]       in_head;
  logic [1:0]       in_orphan;

  // Selection / acceptance
  logic       sel;          // input considered for forwarding this cycle
  logic       cand;         // that input has something forwardable
  logic       idle;
  logic       sel_route;
  logic       can_load;
  logic       fwd_accept;
  logic [1:0] in_ready;
  logic [1:0] grant_c;
  logic       err_c;
  logic [1:0] cred_dec;
  logic [1:0] cred_avail;

  assign in_data[0] = bus.in0_data;
  assign in_data[1] = bus.in1_data;
  assign in_valid   = {bus.in1_valid, bus.in0_valid};

  // Output slot can take a flit if it is empty or being drained now.
  assign can_load = ~out_valid_reg | bus.out_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign in_type[gi]   = in_data[gi][TYPE_MSB -: 2];
      assign in_head[gi]   = in_valid[gi] &  is_head(in_type[gi]);
      assign in_orphan[gi] = in_valid[gi] & ~is_head(in_type[gi]);

      split_credit #(
        .CREDITS (CREDITS)
      ) u_credit (
        .clk    (clk),
        ._reset (_reset),
        .dec    (cred_dec[gi]),
        .inc    (bus.cred_ret[gi]),
        .avail  (cred_avail[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM state register (also holds packet route and round-robin pointer)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_reg <= S_IDLE;
      route_reg <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      route_reg <= route_next;
      last_reg  <= last_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    route_next = route_reg;
    last_next  = last_reg;
    case (state_reg)
      S_IDLE: begin
        if (fwd_accept) begin
          // Any accepted head (with or without tail) moves the pointer.
          last_next = sel;
          if (in_type[sel] == FT_HEAD) begin
            state_next = sel ? S_LOCK1 : S_LOCK0;
            route_next = sel_route;
          end
        end
      end
      S_LOCK0, S_LOCK1: begin
        if (fwd_accept && (in_type[sel] == FT_TAIL)) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs: selection, readies, grant, err, credit consumption
  // -------------------------------------------------------------------------
  always_comb begin
    sel  = 1'b0;
    cand = 1'b0;
    idle = 1'b0;
    case (state_reg)
      S_IDLE: begin
        idle = 1'b1;
        // On contention the input not granted last wins.
        sel  = (in_head[0] & in_head[1]) ? ~last_reg : in_head[1];
        cand = |in_head;
      end
      S_LOCK0: begin
        sel  = 1'b0;
        cand = in_valid[0];
      end
      S_LOCK1: begin
        sel  = 1'b1;
        cand = in_valid[1];
      end
      default: ;
    endcase

    // A head carries its own route; inside a packet the latched one rules.
    sel_route  = idle ? in_data[sel][ROUTE_BIT] : route_reg;
    fwd_accept = _reset & cand & cred_avail[sel_route] & can_load;

    // Orphan body/tail flits in IDLE are swallowed without touching the
    // output slot or credits.
    in_ready[0] = (fwd_accept & ~sel) | (_reset & idle & in_orphan[0]);
    in_ready[1] = (fwd_accept &  sel) | (_reset & idle & in_orphan[1]);
    err_c       = _reset & idle & (|in_orphan);

    grant_c = 2'b00;
    case (state_reg)
      S_LOCK0: grant_c = 2'b01;
      S_LOCK1: grant_c = 2'b10;
      S_IDLE: begin
        if (fwd_accept && (in_type[sel] == FT_HT)) begin
          grant_c = sel ? 2'b10 : 2'b01;
        end
      end
      default: ;
    endcase
    if (!_reset) begin
      grant_c = 2'b00;
    end

    cred_dec = 2'b00;
    if (fwd_accept) begin
      cred_dec = sel_route ? 2'b10 : 2'b01;
    end
  end

  // -------------------------------------------------------------------------
  // Output register: load on accept, otherwise hold until drained
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!_reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ctrl_reg  <= 1'b0;
    end else if (fwd_accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data[sel];
      out_ctrl_reg  <= sel_route;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in0_ready = in_ready[0];
  assign bus.in1_ready = in_ready[1];
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ctrl  = out_ctrl_reg;
  assign bus.grant     = grant_c;
  assign bus.err       = err_c;

endmodule
